// File: rtl/mm2im_pkg.sv
// rtl/mm2im_pkg.sv - shared MM2IM layer geometry, timing constants and scheduler states
package mm2im_pkg;

  localparam int NUM_LAYERS     = 4;
  localparam int JOBS_PER_LAYER = 1024;
  localparam int IDX_W          = $clog2(JOBS_PER_LAYER);
  localparam int MAP_LATENCY    = 3;
  localparam int MAP_TIMEOUT    = 7;

  // Row/tile tables are shared with the mapper's tile_max values; R*T is constant.
  localparam int LAYER_ROWS  [NUM_LAYERS] = '{32, 64, 128, 256};
  localparam int LAYER_TILES [NUM_LAYERS] = '{32, 16, 8, 4};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_HANDOFF,
    ST_FINISH
  } state_t;

  function automatic int rows_for_tiles(input int tiles);
    int rows;
    rows = 0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (LAYER_TILES[i] == tiles) rows = LAYER_ROWS[i];
    end
    return rows;
  endfunction

endpackage

// File: rtl/mm2im_tile_counter.sv
// rtl/mm2im_tile_counter.sv - row-outer / tile-inner job counter for one layer
module mm2im_tile_counter
  import mm2im_pkg::*;
#(
  parameter int ROW_W  = 9,
  parameter int TILE_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  input  logic [TILE_W-1:0] tiles,
  output logic [ROW_W-1:0]  row,
  output logic [TILE_W-1:0] tile,
  output logic              last
);

  logic tile_last;
  logic row_last;

  assign tile_last = (tile == tiles - TILE_W'(1));
  assign row_last  = (row == ROW_W'(rows_for_tiles(int'(tiles)) - 1));
  assign last      = tile_last && row_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row  <= '0;
      tile <= '0;
    end else if (clear) begin
      row  <= '0;
      tile <= '0;
    end else if (advance) begin
      if (tile_last) begin
        tile <= '0;
        row  <= row + ROW_W'(1);
      end else begin
        tile <= tile + TILE_W'(1);
      end
    end
  end

endmodule

// File: rtl/mm2im_scheduler.sv
// rtl/mm2im_scheduler.sv - walks a layer's (row, tile) jobs through the MM2IM mapper
module mm2im_scheduler
  import mm2im_pkg::*;
#(
  parameter int ROW_W  = 9,
  parameter int TILE_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic [1:0]        cfg_layer_id,
  input  logic              abort,
  output logic              busy,
  output logic              layer_done,
  output logic              err_timeout,
  output logic              map_start,
  output logic [ROW_W-1:0]  map_row_id,
  output logic [TILE_W-1:0] map_tile_id,
  output logic [1:0]        map_layer_id,
  input  logic              map_done,
  output logic              job_valid,
  input  logic              job_ready,
  output logic              job_last,
  output logic [IDX_W-1:0]  job_idx
);

  state_t            state, state_nxt;
  logic [2:0]        wait_cnt;
  logic [1:0]        layer_q;
  logic [IDX_W-1:0]  idx_q;
  logic              err_q;
  logic              start_acc, accept, timeout, advance, ctr_last;
  logic [TILE_W-1:0] tiles;

  assign tiles     = TILE_W'(LAYER_TILES[layer_q]);
  assign start_acc = (state == ST_IDLE) && cfg_start;
  assign accept    = (state == ST_HANDOFF) && job_ready && !abort;
  assign timeout   = (state == ST_WAIT) && !map_done && !abort &&
                     (wait_cnt == 3'(MAP_TIMEOUT));
  assign advance   = accept && !ctr_last;

  mm2im_tile_counter #(.ROW_W(ROW_W), .TILE_W(TILE_W)) u_tile_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (start_acc),
    .advance (advance),
    .tiles   (tiles),
    .row     (map_row_id),
    .tile    (map_tile_id),
    .last    (ctr_last)
  );

  always_comb begin
    state_nxt  = state;
    busy       = (state != ST_IDLE);
    map_start  = 1'b0;
    job_valid  = 1'b0;
    job_last   = 1'b0;
    layer_done = 1'b0;
    case (state)
      ST_IDLE:    if (cfg_start) state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        map_start = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (map_done)     state_nxt = ST_HANDOFF;
        else if (timeout) state_nxt = ST_IDLE;
      end
      ST_HANDOFF: begin
        job_valid = 1'b1;
        job_last  = ctr_last;
        if (job_ready) state_nxt = ctr_last ? ST_FINISH : ST_ISSUE;
      end
      ST_FINISH: begin
        layer_done = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default:    state_nxt = ST_IDLE;
    endcase
    // Cancel wins over done, acceptance and timeout alike.
    if (abort && state != ST_IDLE) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      layer_q  <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + 3'd1 : 3'd0;
      if (start_acc) begin
        layer_q <= cfg_layer_id;
        idx_q   <= '0;
        err_q   <= 1'b0;
      end else begin
        if (timeout) err_q <= 1'b1;
        if (advance) idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  assign map_layer_id = layer_q;
  assign job_idx      = idx_q;
  assign err_timeout  = err_q;

endmodule
